// File: rtl/shift_add_sched.sv
// Round-robin scheduler sharing one iterative signed shift-add datapath
// (acc <= acc + (acc >>> SHIFT), repeated per-job iter times) between two requesters.
// Latency: result valid iter edges after accept; backpressure holds DONE until res_ready.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   reqN_valid/ready    job handshake for requester N (ready only in IDLE, for the granted N)
//   reqN_data/iter      signed operand and iteration count for requester N
//   res_valid/ready     result handshake
//   res_data/res_id     signed result and the requester that owns it
module shift_add_sched #(
    parameter int DATA_W = 32,
    parameter int SHIFT  = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [CNT_W-1:0]  req0_iter,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [CNT_W-1:0]  req1_iter,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_id
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state_q, state_d;
    logic signed [DATA_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      id_q, id_d;
    logic                      last_grant_q, last_grant_d;
    logic                      gnt0, gnt1;

    // A lone requester always wins; on contention the one not served last wins.
    assign gnt0 = req0_valid && (!req1_valid || last_grant_q);
    assign gnt1 = req1_valid && (!req0_valid || !last_grant_q);

    // rst gating keeps readies low while reset is held (state already reads IDLE then).
    assign req0_ready = (state_q == IDLE) && gnt0 && !rst;
    assign req1_ready = (state_q == IDLE) && gnt1 && !rst;

    assign res_valid = (state_q == DONE);
    assign res_data  = acc_q;
    assign res_id    = id_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    acc_d   = req0_data;
                    cnt_d   = req0_iter;
                    id_d    = 1'b0;
                    state_d = (req0_iter == '0) ? DONE : RUN;
                end else if (req1_ready) begin
                    acc_d   = req1_data;
                    cnt_d   = req1_iter;
                    id_d    = 1'b1;
                    state_d = (req1_iter == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Arithmetic shift floors toward -inf; the add wraps at DATA_W bits.
                acc_d = acc_q + (acc_q >>> SHIFT);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d      = IDLE;
                    last_grant_d = id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_shift_add_sched.sv
// Bench for shift_add_sched: table-driven jobs plus hand-written arbitration,
// backpressure and mid-run reset sequences; a negedge monitor checks results
// against a queue of expectations pushed when each job is driven.
module tb_shift_add_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic [3:0]  req0_iter = '0, req1_iter = '0;
    logic        res_valid, res_id;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;

    shift_add_sched #(.DATA_W(32), .SHIFT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data(req0_data), .req0_iter(req0_iter),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data(req1_data), .req1_iter(req1_iter),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [3:0]  iter;
    } exp_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [3:0]  iter;
        logic [31:0] exp;
    } vec_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;
    int   rise_cyc = 0;
    logic vld_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            vld_prev = 1'b0;
        end else begin
            chk("both_ready", 32'(req0_ready && req1_ready), 32'd0);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                acc_cyc = cyc;
                if (exp_q.size() == 0) fail_now("unexpected_accept");
                else chk("grant_id", 32'(req1_valid && req1_ready), 32'(exp_q[0].id));
            end
            if (res_valid && !vld_prev) rise_cyc = cyc;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("spurious_result");
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("res_data", res_data, x.data);
                    chk("res_id", 32'(res_id), 32'(x.id));
                    chk("latency", 32'(rise_cyc - acc_cyc - 1), 32'(x.iter));
                end
            end
            vld_prev = res_valid;
        end
    end

    task automatic wait_empty();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            fail_now("result_timeout");
            exp_q.delete();
        end
    endtask

    task automatic wait_ready(input logic id);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        if (!got) fail_now("accept_timeout");
    endtask

    task automatic do_job(input logic id, input logic [31:0] d, input logic [3:0] it,
                          input logic [31:0] e);
        exp_t x;
        @(posedge clk); #1;
        x.id = id; x.data = e; x.iter = it;
        exp_q.push_back(x);
        if (id) begin
            req1_valid = 1'b1; req1_data = d; req1_iter = it;
        end else begin
            req0_valid = 1'b1; req0_data = d; req0_iter = it;
        end
        wait_ready(id);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_empty();
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    vec_t vecs[9];

    initial begin
        exp_t x;
        int   n_acc;

        vecs[0] = '{1'b0, 32'd16,         4'd1,  32'd17};
        vecs[1] = '{1'b1, 32'd256,        4'd2,  32'd289};
        vecs[2] = '{1'b0, 32'hFFFF_FFF0,  4'd1,  32'hFFFF_FFEF};  // -16 -> -17
        vecs[3] = '{1'b1, 32'hFFFF_FFFF,  4'd3,  32'hFFFF_FFFC};  // -1 -> -4
        vecs[4] = '{1'b0, 32'h7FFF_FFFF,  4'd1,  32'h87FF_FFFE};  // wraps
        vecs[5] = '{1'b1, 32'd1234,       4'd0,  32'd1234};       // pass-through
        vecs[6] = '{1'b0, 32'h8000_0000,  4'd2,  32'h7F80_0000};  // wraps negative
        vecs[7] = '{1'b1, 32'd0,          4'd15, 32'd0};          // max iterations
        vecs[8] = '{1'b0, 32'd1000,       4'd0,  32'd1000};

        // Reset state, with a requester valid to show readies are held low.
        req0_valid = 1'b1;
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_job(vecs[i].id, vecs[i].data, vecs[i].iter, vecs[i].exp);
        end

        // Arbitration: both valid continuously from reset, order 0,1,0,1.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            x.id   = i[0];
            x.data = i[0] ? 32'd212 : 32'd106;
            x.iter = 4'd1;
            exp_q.push_back(x);
        end
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data = 32'd100; req0_iter = 4'd1;
        req1_valid = 1'b1; req1_data = 32'd200; req1_iter = 4'd1;
        n_acc = 0;
        for (int i = 0; i < 100 && n_acc < 4; i++) begin
            @(negedge clk);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) n_acc++;
        end
        if (n_acc < 4) fail_now("arb_accept_timeout");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_empty();

        // Backpressure: result held 10 cycles; req1 waits and is served afterwards.
        @(posedge clk); #1;
        res_ready = 1'b0;
        x.id = 1'b0; x.data = 32'd17; x.iter = 4'd1;
        exp_q.push_back(x);
        req0_valid = 1'b1; req0_data = 32'd16; req0_iter = 4'd1;
        wait_ready(1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        x.id = 1'b1; x.data = 32'd32; x.iter = 4'd0;
        exp_q.push_back(x);
        req1_valid = 1'b1; req1_data = 32'd32; req1_iter = 4'd0;
        for (int i = 0; i < 50 && !res_valid; i++) @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_res_data", res_data, 32'd17);
            chk("bp_res_id", 32'(res_id), 32'd0);
            chk("bp_readies", 32'(req0_ready || req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_ready(1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_empty();

        // Mid-run reset: leave last_grant=0 so only reset can restore req0 priority.
        do_job(1'b0, 32'd5, 4'd1, 32'd5);
        @(posedge clk); #1;
        x.id = 1'b0; x.data = 32'd0; x.iter = 4'd5;
        exp_q.push_back(x);
        req0_valid = 1'b1; req0_data = 32'd1000; req0_iter = 4'd5;
        wait_ready(1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data = 32'd48; req0_iter = 4'd1;
        req1_valid = 1'b1; req1_data = 32'd64; req1_iter = 4'd1;
        #2 rst = 1'b1;
        #1;
        chk("mrst_res_valid", 32'(res_valid), 32'd0);
        chk("mrst_res_data", res_data, 32'd0);
        chk("mrst_res_id", 32'(res_id), 32'd0);
        chk("mrst_readies", 32'(req0_ready || req1_ready), 32'd0);
        exp_q.delete();
        x.id = 1'b0; x.data = 32'd51; x.iter = 4'd1;
        exp_q.push_back(x);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        wait_ready(1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_empty();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_add_sched.md
Name: shift_add_sched

Overview:
- Round-robin scheduler that shares one iterative signed shift-add datapath between two requesters.
- Each accepted job repeatedly applies acc <= acc + (acc >>> SHIFT), i.e. scale by (1 + 2^-SHIFT), for a per-job iteration count.
- Result returns on a single valid/ready port tagged with the requester ID.
- Sits between the two client pipelines and the scaling datapath of the midterm design.

Parameters:
- DATA_W, 32, signed data width of operands and result.
- SHIFT, 4, arithmetic right-shift amount per iteration.
- CNT_W, 4, width of iteration count (max 2^CNT_W-1 iterations).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 job accepted this cycle.
- req0_data  in  DATA_W  requester 0 signed operand.
- req0_iter  in  CNT_W  requester 0 iteration count.
- req1_valid  in  1  requester 1 has a job.
- req1_ready  out  1  requester 1 job accepted this cycle.
- req1_data  in  DATA_W  requester 1 signed operand.
- req1_iter  in  CNT_W  requester 1 iteration count.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  DATA_W  signed result.
- res_id  out  1  requester that owns res_data.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, acc=0, cnt=0, res_id=0, last_grant=1 (so req0 wins first).
  - res_valid=0, res_data=0.
  - req0_ready and req1_ready are forced 0 while rst is high.
- FSM states: IDLE, RUN, DONE.
- IDLE, arbitration:
  - Only one requester valid: it is granted.
  - Both valid: grant the one not equal to last_grant.
  - reqN_ready=1 combinationally only in IDLE for the granted N; both readies are 0 in RUN and DONE.
- IDLE, accept (valid&&ready at an edge):
  - acc<=reqN_data, cnt<=reqN_iter, res_id<=N.
  - Next state is DONE if iter==0, otherwise RUN.
- RUN: every edge performs acc <= acc + (acc >>> SHIFT) and cnt <= cnt-1. When cnt==1 at that edge, next state is DONE.
- Latency: res_valid rises exactly N edges after the accept edge. For N=0 that is the cycle immediately after accept (pass-through).
- DONE:
  - res_valid=1, res_data=acc, res_id is held.
  - Outputs are stable while res_ready=0 (unbounded backpressure).
  - On an edge with res_ready=1: go to IDLE and set last_grant<=res_id.
  - The next job can be accepted in the cycle after the handshake, so throughput is one job per N+2 cycles.
- Arithmetic:
  - Shift is arithmetic (sign-extending), floor toward -inf.
  - Add wraps modulo 2^DATA_W; there is no saturation or overflow flag.
  - Per-iteration result is truncated to DATA_W.
- Requests arriving outside IDLE are not accepted. Requesters must hold valid, data and iter stable until ready.
- Simultaneous events:
  - A new request arriving in the same cycle as the DONE handshake is not accepted in that cycle.
  - It is arbitrated in the following IDLE cycle using the updated last_grant.
- Reset mid-operation: the job is abandoned, no result is emitted, and the FSM restarts in IDLE with req0 priority.
- res_data shows acc in every state. It is only meaningful while res_valid=1.

Test Plan:
- Basic and multi-iteration:
  - req0 data=16, iter=1 -> res_valid one edge after accept; res_data=17, res_id=0.
  - req1 data=256, iter=2 -> 256->272->289; res_data=289, res_id=1, 2 cycles after accept.
- Negative values:
  - data=-16, iter=1 -> res_data=-17.
  - data=-1, iter=3 -> -2, -3, -4; res_data=-4.
- Wrap and pass-through:
  - data=0x7FFFFFFF, iter=1 -> res_data=0x87FFFFFE (wraps).
  - data=1234, iter=0 -> res_valid the cycle after accept, res_data=1234.
- Arbitration: both requesters continuously valid from reset, each job iter=1 -> grant order req0, req1, req0, req1; no requester starves; ready never high for both at once.
- Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid, res_data and res_id remain stable; both readies remain 0; completion occurs only on res_ready=1.
- Reset mid-RUN: assert rst during iteration 2 of an iter=5 job -> all outputs return to reset values immediately (asynchronous); no res_valid pulse; the next job with both requesters valid is granted to req0.
